common_dffcam_alloc_ctrl: RTL and testbench
===========================================

COMMON_DFFCAM_ALLOC_CTRL -- requirements
Module: common_dffcam_alloc_ctrl

Interface
REQ-001 SHALL have parameter CAM_DEPTH, default 8: number of CAM entries, power of two, at least 2.
REQ-002 SHALL have parameter CAM_WIDTH, default 8: key width in bits.
REQ-003 SHALL have a single clock and an asynchronous, active-low reset: clk (input, 1 bit, sole clock) and reset (input, 1 bit, asynchronous active-low reset).
REQ-004 SHALL have the insert request port: ins_valid (input, 1), ins_ready (output, 1), ins_data (input, CAM_WIDTH), the key to insert.
REQ-005 SHALL have the invalidate request port: inv_valid (input, 1), inv_ready (output, 1), inv_data (input, CAM_WIDTH), the key to remove.
REQ-006 SHALL have the flush port: flush (input, 1), a one-cycle pulse that invalidates all entries.
REQ-007 SHALL have the response port: rsp_valid (output, 1), rsp_addr (output, $clog2(CAM_DEPTH)), rsp_hit (output, 1), rsp_evict (output, 1), rsp_inv (output, 1).
REQ-008 SHALL have the CAM write side: cam_addr (output, $clog2(CAM_DEPTH), binary), cam_en (output, 1), cam_we (output, 1), cam_din (output, CAM_WIDTH), cam_din_valid (output, 1).
REQ-009 SHALL have the CAM query side: cam_qdata (output, CAM_WIDTH), cam_qaddr (input, $clog2(CAM_DEPTH), binary), cam_qvalid (input, 1).
REQ-010 SHALL have the status outputs: busy (output, 1), occupancy (output, $clog2(CAM_DEPTH+1)), full (output, 1).

Function
REQ-011 SHALL implement a 3-state FSM: IDLE, WRITE, FLUSH.
REQ-012 SHALL treat the CAM query as combinational: cam_qdata is driven in IDLE, and cam_qaddr and cam_qvalid are sampled at the same clock edge.
REQ-013 SHALL give priority in IDLE as flush > inv_valid > ins_valid.
REQ-014 SHALL drive inv_ready=1 in IDLE when flush=0.
REQ-015 SHALL drive ins_ready=1 in IDLE when flush=0 and inv_valid=0; both readys SHALL be 0 in every other state.
REQ-016 SHALL, on an accepted request, drive cam_qdata with the request key, register the key, op type, qvalid and qaddr, and move to WRITE; when nothing is accepted, cam_qdata SHALL be ins_data.
REQ-017 SHALL, for an insert hit in WRITE, keep cam_en=0 and drive rsp_hit=1 with rsp_addr=qaddr.
REQ-018 SHALL, for an insert miss with a free entry, write the lowest-index entry whose shadow valid bit is 0: cam_en=cam_we=1, cam_din=key, cam_din_valid=1, rsp_evict=0.
REQ-019 SHALL, for an insert miss when full, write the entry at the round-robin victim pointer with rsp_evict=1, then advance the pointer by 1 modulo CAM_DEPTH.
REQ-020 SHALL advance the victim pointer on eviction only.
REQ-021 SHALL, for an invalidate hit, write cam_addr=qaddr with cam_din_valid=0 and drive rsp_inv=1, rsp_hit=1.
REQ-022 SHALL, for an invalidate miss, keep cam_en=0 and drive rsp_inv=1, rsp_hit=0.
REQ-023 SHALL assert rsp_valid for exactly one cycle, in WRITE, so response latency is 1 cycle after acceptance; WRITE SHALL always return to IDLE.
REQ-024 SHALL maintain a shadow valid vector that is updated on every CAM write.
REQ-025 SHALL keep occupancy equal to the popcount of the shadow valid vector and assert full when occupancy == CAM_DEPTH.
REQ-026 SHALL keep occupancy unchanged on an eviction.
REQ-027 SHALL, in FLUSH, write cam_addr = 0..CAM_DEPTH-1 on consecutive cycles with cam_din_valid=0 and cam_din=0, clear the shadow bits, and return to IDLE after the last address; FLUSH lasts CAM_DEPTH cycles with no response.
REQ-028 SHALL ignore flush outside IDLE; the requester retries.
REQ-029 SHALL drive busy=1 in WRITE and FLUSH.
REQ-030 SHALL drive cam_we equal to cam_en.

Reset
REQ-031 SHALL, on reset assertion, immediately force: state IDLE, shadow valid all 0, victim pointer 0, flush counter 0.
REQ-032 SHALL, during reset, drive every output to 0 except ins_ready and inv_ready, which SHALL also be 0.
REQ-033 SHALL leave the CAM contents to the CAM's own reset; a reset in mid-WRITE or mid-FLUSH abandons the operation with no response.
REQ-034 SHALL release reset synchronously to clk, handled by the system-level synchronizer.

Structure
REQ-035 SHALL place the FSM state encoding (2-bit) and the response-type constants in package common_dffcam_pkg.
REQ-036 SHALL select the lowest free entry through one sub-module, macro_encoder_priority_lsb (input CAM_DEPTH bits, output binary index plus found flag).
REQ-037 SHALL keep all other logic in this module.

Verification
REQ-038 SHALL verify insert into empty CAM: DEPTH=8, insert 0x11 -> rsp one cycle later, rsp_addr=0, hit=0, evict=0, occupancy=1.
REQ-039 SHALL verify duplicate insert: insert 0x11 again -> rsp_hit=1, rsp_addr=0, cam_en=0, occupancy=1.
REQ-040 SHALL verify full-CAM eviction: fill 8 keys, then insert 0x99 -> rsp_evict=1, addr=0; next insert 0xAA -> evict addr=1; occupancy stays 8.
REQ-041 SHALL verify invalidate then re-insert: invalidate key at addr 3 -> rsp_inv=1, hit=1, occupancy=7; next insert miss -> addr=3.
REQ-042 SHALL verify simultaneous requests: inv_valid and ins_valid in the same IDLE cycle -> only inv accepted, ins_ready=0, ins accepted on the cycle after WRITE.
REQ-043 SHALL verify flush and reset: flush -> busy for 8 cycles, cam_addr 0..7, occupancy=0; reset asserted mid-FLUSH -> outputs 0 immediately, state IDLE after release.

Source files
------------

// File: rtl/common_dffcam_pkg.sv
// Shared types for the DFF-CAM allocation controller: FSM state encoding and
// the response-type flag constants driven on the response port.
package common_dffcam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_FLUSH = 2'b10
  } state_e;

  typedef enum logic {
    OP_INS = 1'b0,
    OP_INV = 1'b1
  } op_e;

  typedef struct packed {
    logic hit;
    logic evict;
    logic inv;
  } rsp_flags_t;

  localparam rsp_flags_t RSP_NONE      = '{hit: 1'b0, evict: 1'b0, inv: 1'b0};
  localparam rsp_flags_t RSP_INS_MISS  = '{hit: 1'b0, evict: 1'b0, inv: 1'b0};
  localparam rsp_flags_t RSP_INS_HIT   = '{hit: 1'b1, evict: 1'b0, inv: 1'b0};
  localparam rsp_flags_t RSP_INS_EVICT = '{hit: 1'b0, evict: 1'b1, inv: 1'b0};
  localparam rsp_flags_t RSP_INV_HIT   = '{hit: 1'b1, evict: 1'b0, inv: 1'b1};
  localparam rsp_flags_t RSP_INV_MISS  = '{hit: 1'b0, evict: 1'b0, inv: 1'b1};

endpackage

// File: rtl/macro_encoder_priority_lsb.sv
// Priority encoder: returns the index of the lowest set request bit and a
// found flag that is low when no bit is set.
module macro_encoder_priority_lsb #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  // Scanning from the top down lets the lowest set bit overwrite the result last.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IDX_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/common_dffcam_alloc_ctrl.sv
// Allocation controller for a flip-flop CAM: accepts insert/invalidate/flush
// requests, picks a free or round-robin victim entry, and drives the CAM write port.
module common_dffcam_alloc_ctrl
  import common_dffcam_pkg::*;
#(
  parameter int CAM_DEPTH = 8,
  parameter int CAM_WIDTH = 8,
  localparam int AW = $clog2(CAM_DEPTH),
  localparam int OW = $clog2(CAM_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ins_valid,
  output logic                 ins_ready,
  input  logic [CAM_WIDTH-1:0] ins_data,
  input  logic                 inv_valid,
  output logic                 inv_ready,
  input  logic [CAM_WIDTH-1:0] inv_data,
  input  logic                 flush,
  output logic                 rsp_valid,
  output logic [AW-1:0]        rsp_addr,
  output logic                 rsp_hit,
  output logic                 rsp_evict,
  output logic                 rsp_inv,
  output logic [AW-1:0]        cam_addr,
  output logic                 cam_en,
  output logic                 cam_we,
  output logic [CAM_WIDTH-1:0] cam_din,
  output logic                 cam_din_valid,
  output logic [CAM_WIDTH-1:0] cam_qdata,
  input  logic [AW-1:0]        cam_qaddr,
  input  logic                 cam_qvalid,
  output logic                 busy,
  output logic [OW-1:0]        occupancy,
  output logic                 full
);

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [CAM_WIDTH-1:0] key_q, key_d;
  logic                 qvalid_q, qvalid_d;
  logic [AW-1:0]        qaddr_q, qaddr_d;
  logic [AW-1:0]        victim_q, victim_d;
  logic [AW-1:0]        flush_cnt_q, flush_cnt_d;
  logic [CAM_DEPTH-1:0] shadow_q, shadow_d;
  logic [AW-1:0]        free_idx;
  logic                 free_found;
  rsp_flags_t           rsp_flags;

  macro_encoder_priority_lsb #(
    .WIDTH (CAM_DEPTH)
  ) u_free_enc (
    .req_i   (~shadow_q),
    .idx_o   (free_idx),
    .found_o (free_found)
  );

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < CAM_DEPTH; i++) begin
      occupancy = occupancy + OW'(shadow_q[i]);
    end
  end

  assign full      = (occupancy == OW'(CAM_DEPTH));
  assign cam_we    = cam_en;
  assign rsp_hit   = rsp_flags.hit;
  assign rsp_evict = rsp_flags.evict;
  assign rsp_inv   = rsp_flags.inv;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through the case can infer a latch.
    state_d       = state_q;
    op_d          = op_q;
    key_d         = key_q;
    qvalid_d      = qvalid_q;
    qaddr_d       = qaddr_q;
    victim_d      = victim_q;
    flush_cnt_d   = flush_cnt_q;
    shadow_d      = shadow_q;
    ins_ready     = 1'b0;
    inv_ready     = 1'b0;
    cam_qdata     = '0;
    cam_en        = 1'b0;
    cam_addr      = '0;
    cam_din       = '0;
    cam_din_valid = 1'b0;
    rsp_valid     = 1'b0;
    rsp_addr      = '0;
    rsp_flags     = RSP_NONE;
    busy          = 1'b0;

    // Outputs stay quiet while reset is held, including the IDLE readys.
    if (reset) begin
      unique case (state_q)
        ST_IDLE: begin
          inv_ready = !flush;
          ins_ready = !flush && !inv_valid;
          cam_qdata = ins_data;
          if (flush) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = '0;
          end else if (inv_valid) begin
            cam_qdata = inv_data;
            key_d     = inv_data;
            op_d      = OP_INV;
            qvalid_d  = cam_qvalid;
            qaddr_d   = cam_qaddr;
            state_d   = ST_WRITE;
          end else if (ins_valid) begin
            key_d    = ins_data;
            op_d     = OP_INS;
            qvalid_d = cam_qvalid;
            qaddr_d  = cam_qaddr;
            state_d  = ST_WRITE;
          end
        end

        ST_WRITE: begin
          busy      = 1'b1;
          rsp_valid = 1'b1;
          state_d   = ST_IDLE;
          if (op_q == OP_INV) begin
            if (qvalid_q) begin
              cam_en            = 1'b1;
              cam_addr          = qaddr_q;
              cam_din           = key_q;
              shadow_d[qaddr_q] = 1'b0;
              rsp_addr          = qaddr_q;
              rsp_flags         = RSP_INV_HIT;
            end else begin
              rsp_flags = RSP_INV_MISS;
            end
          end else if (qvalid_q) begin
            rsp_addr  = qaddr_q;
            rsp_flags = RSP_INS_HIT;
          end else begin
            cam_en        = 1'b1;
            cam_din       = key_q;
            cam_din_valid = 1'b1;
            if (free_found) begin
              cam_addr  = free_idx;
              rsp_flags = RSP_INS_MISS;
            end else begin
              // Evicting swaps one valid key for another, so occupancy is unchanged.
              cam_addr  = victim_q;
              victim_d  = victim_q + AW'(1);
              rsp_flags = RSP_INS_EVICT;
            end
            shadow_d[cam_addr] = 1'b1;
            rsp_addr           = cam_addr;
          end
        end

        ST_FLUSH: begin
          busy                  = 1'b1;
          cam_en                = 1'b1;
          cam_addr              = flush_cnt_q;
          shadow_d[flush_cnt_q] = 1'b0;
          flush_cnt_d           = flush_cnt_q + AW'(1);
          if (flush_cnt_q == AW'(CAM_DEPTH - 1)) begin
            state_d     = ST_IDLE;
            flush_cnt_d = '0;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the shadow valid bits are plain flops and are reset here; the CAM array itself is reset by its owner.
      state_q     <= ST_IDLE;
      op_q        <= OP_INS;
      key_q       <= '0;
      qvalid_q    <= 1'b0;
      qaddr_q     <= '0;
      victim_q    <= '0;
      flush_cnt_q <= '0;
      shadow_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register update from pre-edge values.
      state_q     <= state_d;
      op_q        <= op_d;
      key_q       <= key_d;
      qvalid_q    <= qvalid_d;
      qaddr_q     <= qaddr_d;
      victim_q    <= victim_d;
      flush_cnt_q <= flush_cnt_d;
      shadow_q    <= shadow_d;
    end
  end

endmodule

// File: tb/tb_common_dffcam_alloc_ctrl.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and
// random insert/invalidate traffic checked against an array-based CAM model.
module tb_common_dffcam_alloc_ctrl;

  localparam int D  = 8;
  localparam int W  = 8;
  localparam int AW = $clog2(D);
  localparam int OW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          ins_valid, inv_valid, flush;
  logic [W-1:0]  ins_data, inv_data;
  logic          ins_ready, inv_ready;
  logic          rsp_valid, rsp_hit, rsp_evict, rsp_inv;
  logic [AW-1:0] rsp_addr, cam_addr, cam_qaddr;
  logic          cam_en, cam_we, cam_din_valid, cam_qvalid;
  logic [W-1:0]  cam_din, cam_qdata;
  logic          busy, full;
  logic [OW-1:0] occupancy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  common_dffcam_alloc_ctrl #(.CAM_DEPTH(D), .CAM_WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_data(ins_data),
    .inv_valid(inv_valid), .inv_ready(inv_ready), .inv_data(inv_data),
    .flush(flush),
    .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_hit(rsp_hit),
    .rsp_evict(rsp_evict), .rsp_inv(rsp_inv),
    .cam_addr(cam_addr), .cam_en(cam_en), .cam_we(cam_we), .cam_din(cam_din),
    .cam_din_valid(cam_din_valid),
    .cam_qdata(cam_qdata), .cam_qaddr(cam_qaddr), .cam_qvalid(cam_qvalid),
    .busy(busy), .occupancy(occupancy), .full(full)
  );

  // The CAM array the controller drives: written by cam_en, queried combinationally.
  logic [W-1:0] env_key [D];
  logic [D-1:0] env_v;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      env_v <= '0;
      for (int i = 0; i < D; i++) env_key[i] <= '0;
    end else if (cam_en) begin
      env_key[cam_addr] <= cam_din;
      env_v[cam_addr]   <= cam_din_valid;
    end
  end

  always_comb begin
    cam_qvalid = 1'b0;
    cam_qaddr  = '0;
    for (int i = D - 1; i >= 0; i--) begin
      if (env_v[i] && env_key[i] == cam_qdata) begin
        cam_qvalid = 1'b1;
        cam_qaddr  = AW'(i);
      end
    end
  end

  // Reference model: the set of stored keys by slot plus the round-robin victim.
  logic [W-1:0] m_key [D];
  bit           m_v   [D];
  int           m_victim;

  typedef struct {
    bit hit; bit evict; bit inv; bit cam_en; bit chk_addr; int addr; int occ;
  } exp_t;

  typedef struct {
    logic valid; logic hit; logic evict; logic inv; logic cam_en;
    logic [31:0] addr; logic [31:0] occ; logic full;
  } obs_t;

  typedef struct {
    bit is_inv; logic [W-1:0] key; bit hit; bit evict; bit cam_en; int addr; int occ;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < D; i++) m_v[i] = 1'b0;
  endfunction

  function automatic exp_t model_apply(input bit is_inv, input logic [W-1:0] key);
    exp_t e;
    int   hit_idx = -1;
    int   free_idx = -1;
    e = '{default: 0};
    e.inv      = is_inv;
    e.chk_addr = 1'b1;
    for (int i = 0; i < D; i++) if (m_v[i] && m_key[i] == key) hit_idx = i;
    if (is_inv) begin
      if (hit_idx >= 0) begin
        e.hit = 1; e.addr = hit_idx; e.cam_en = 1; m_v[hit_idx] = 1'b0;
      end else begin
        e.chk_addr = 1'b0;
      end
    end else if (hit_idx >= 0) begin
      e.hit = 1; e.addr = hit_idx;
    end else begin
      for (int i = D - 1; i >= 0; i--) if (!m_v[i]) free_idx = i;
      e.cam_en = 1;
      if (free_idx >= 0) begin
        e.addr = free_idx;
      end else begin
        e.addr = m_victim; e.evict = 1; m_victim = (m_victim + 1) % D;
      end
      m_v[e.addr]   = 1'b1;
      m_key[e.addr] = key;
    end
    for (int i = 0; i < D; i++) e.occ += int'(m_v[i]);
    return e;
  endfunction

  // Called just after a rising edge with the DUT idle; returns one cycle after the response.
  task automatic do_req(input bit is_inv, input logic [W-1:0] key, output obs_t o);
    int n = 0;
    if (is_inv) begin inv_valid = 1'b1; inv_data = key; end
    else        begin ins_valid = 1'b1; ins_data = key; end
    @(negedge clk);
    while (!(is_inv ? inv_ready : ins_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    inv_valid = 1'b0;
    ins_valid = 1'b0;
    @(negedge clk);
    o.valid = rsp_valid; o.hit = rsp_hit; o.evict = rsp_evict; o.inv = rsp_inv;
    o.cam_en = cam_en; o.addr = 32'(rsp_addr);
    @(posedge clk); #1;
    o.occ  = 32'(occupancy);
    o.full = full;
  endtask

  task automatic compare_rsp(input string tag, input obs_t o, input exp_t e);
    check({tag, " rsp_valid"}, 32'(o.valid), 32'd1);
    check({tag, " rsp_hit"},   32'(o.hit),   32'(e.hit));
    check({tag, " rsp_evict"}, 32'(o.evict), 32'(e.evict));
    check({tag, " rsp_inv"},   32'(o.inv),   32'(e.inv));
    check({tag, " cam_en"},    32'(o.cam_en), 32'(e.cam_en));
    if (e.chk_addr) check({tag, " rsp_addr"}, o.addr, 32'(e.addr));
    check({tag, " occupancy"}, o.occ, 32'(e.occ));
    check({tag, " full"},      32'(o.full), 32'(e.occ == D));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t vecs [14];
    obs_t o;
    exp_t e;

    vecs[0]  = '{1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 0, 1};
    vecs[1]  = '{1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 0, 1};
    vecs[2]  = '{1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 1, 2};
    vecs[3]  = '{1'b0, 8'h33, 1'b0, 1'b0, 1'b1, 2, 3};
    vecs[4]  = '{1'b0, 8'h44, 1'b0, 1'b0, 1'b1, 3, 4};
    vecs[5]  = '{1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 4, 5};
    vecs[6]  = '{1'b0, 8'h66, 1'b0, 1'b0, 1'b1, 5, 6};
    vecs[7]  = '{1'b0, 8'h77, 1'b0, 1'b0, 1'b1, 6, 7};
    vecs[8]  = '{1'b0, 8'h88, 1'b0, 1'b0, 1'b1, 7, 8};
    vecs[9]  = '{1'b0, 8'h99, 1'b0, 1'b1, 1'b1, 0, 8};
    vecs[10] = '{1'b0, 8'hAA, 1'b0, 1'b1, 1'b1, 1, 8};
    vecs[11] = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 3, 7};
    vecs[12] = '{1'b0, 8'hBB, 1'b0, 1'b0, 1'b1, 3, 8};
    vecs[13] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 0, 8};

    reset     = 1'b0;
    ins_valid = 1'b0;
    inv_valid = 1'b0;
    flush     = 1'b0;
    ins_data  = 8'h5A;
    inv_data  = 8'h00;
    model_clear();
    m_victim  = 0;

    #3;
    check("reset ins_ready", 32'(ins_ready), 32'd0);
    check("reset inv_ready", 32'(inv_ready), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset occupancy", 32'(occupancy), 32'd0);
    check("reset cam_qdata", 32'(cam_qdata), 32'd0);
    check("reset cam_en", 32'(cam_en), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("idle inv_ready", 32'(inv_ready), 32'd1);
    check("idle cam_qdata", 32'(cam_qdata), 32'h5A);

    // Directed table: fill, duplicate, evict, invalidate, re-insert.
    for (int i = 0; i < 14; i++) begin
      do_req(vecs[i].is_inv, vecs[i].key, o);
      e = model_apply(vecs[i].is_inv, vecs[i].key);
      e.hit      = vecs[i].hit;
      e.evict    = vecs[i].evict;
      e.cam_en   = vecs[i].cam_en;
      e.addr     = vecs[i].addr;
      e.occ      = vecs[i].occ;
      e.chk_addr = !(vecs[i].is_inv && !vecs[i].hit);
      compare_rsp($sformatf("vec%0d", i), o, e);
    end

    // Simultaneous invalidate and insert: invalidate wins, insert follows WRITE.
    inv_valid = 1'b1; inv_data = 8'h33;
    ins_valid = 1'b1; ins_data = 8'hCC;
    @(negedge clk);
    check("sim ins_ready", 32'(ins_ready), 32'd0);
    check("sim inv_ready", 32'(inv_ready), 32'd1);
    check("sim cam_qdata", 32'(cam_qdata), 32'h33);
    @(posedge clk); #1;
    inv_valid = 1'b0;
    @(negedge clk);
    e = model_apply(1'b1, 8'h33);
    check("sim inv rsp_inv", 32'(rsp_inv), 32'd1);
    check("sim inv rsp_hit", 32'(rsp_hit), 32'(e.hit));
    check("sim inv rsp_addr", 32'(rsp_addr), 32'(e.addr));
    check("sim write ins_ready", 32'(ins_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("sim after ins_ready", 32'(ins_ready), 32'd1);
    @(posedge clk); #1;
    ins_valid = 1'b0;
    @(negedge clk);
    e = model_apply(1'b0, 8'hCC);
    check("sim ins rsp_valid", 32'(rsp_valid), 32'd1);
    check("sim ins rsp_inv", 32'(rsp_inv), 32'd0);
    check("sim ins rsp_addr", 32'(rsp_addr), 32'(e.addr));
    @(posedge clk); #1;
    check("sim occupancy", 32'(occupancy), 32'(e.occ));

    // Random traffic over a small key pool so hits, misses and evictions all occur.
    for (int i = 0; i < 150; i++) begin
      bit           r_inv;
      logic [W-1:0] r_key;
      r_inv = ($urandom_range(0, 3) == 0);
      r_key = W'($urandom_range(0, 15));
      do_req(r_inv, r_key, o);
      e = model_apply(r_inv, r_key);
      compare_rsp($sformatf("rnd%0d", i), o, e);
    end

    // Flush: CAM_DEPTH busy cycles sweeping every address, no response.
    flush = 1'b1;
    @(negedge clk);
    check("flush inv_ready", 32'(inv_ready), 32'd0);
    check("flush ins_ready", 32'(ins_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    for (int i = 0; i < D; i++) begin
      @(negedge clk);
      check($sformatf("flush%0d busy", i), 32'(busy), 32'd1);
      check($sformatf("flush%0d cam_addr", i), 32'(cam_addr), 32'(i));
      check($sformatf("flush%0d cam_en", i), 32'(cam_en & cam_we), 32'd1);
      check($sformatf("flush%0d din_valid", i), 32'(cam_din_valid), 32'd0);
      check($sformatf("flush%0d rsp_valid", i), 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
    end
    model_clear();
    check("flush done busy", 32'(busy), 32'd0);
    check("flush done occupancy", 32'(occupancy), 32'd0);

    // Refill a little, then reset in the middle of a flush.
    do_req(1'b0, 8'hD1, o);
    do_req(1'b0, 8'hD2, o);
    check("refill occupancy", o.occ, 32'd2);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    ins_data = 8'h5A;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("midflush busy", 32'(busy), 32'd0);
    check("midflush cam_en", 32'(cam_en), 32'd0);
    check("midflush cam_addr", 32'(cam_addr), 32'd0);
    check("midflush inv_ready", 32'(inv_ready), 32'd0);
    check("midflush cam_qdata", 32'(cam_qdata), 32'd0);
    check("midflush occupancy", 32'(occupancy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post reset inv_ready", 32'(inv_ready), 32'd1);
    check("post reset busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
